// File: rtl/bin_lookup_sequencer.sv
// bin_lookup_sequencer: controller for one BIN lookup.
// Accepts a BIN request, kicks off the binary search, then feeds the found index/found flag
// into the bank-name and card-level lookup units. It collects both results and holds them
// until the consumer acknowledges. A timer bounds SEARCH+LOOKUP so a stalled unit cannot hang
// the design.
// Ports:
//   CLOCK_50, resetn                - clock, async active-low reset
//   req_valid/req_bin/req_ready     - request handshake (accepted in IDLE only)
//   bs_start/bs_bin                 - start pulse and latched BIN to binary search
//   bs_done/bs_found/bs_index       - binary-search result (level)
//   lk_index/lk_done/lk_found       - latched search result to the lookup units
//   name_done/name_in               - bank-name lookup result
//   level_done/level_in             - card-level lookup result
//   res_valid/found/timeout/name/level, res_ack - held result and consumer acknowledge
//   busy                            - sequencer not idle
module bin_lookup_sequencer #(
  parameter int unsigned BIN_W   = 20,
  parameter int unsigned IDX_W   = 12,
  parameter int unsigned NAME_W  = 100,
  parameter int unsigned LEVEL_W = 100,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               req_valid,
  input  logic [BIN_W-1:0]   req_bin,
  output logic               req_ready,
  output logic               bs_start,
  output logic [BIN_W-1:0]   bs_bin,
  input  logic               bs_done,
  input  logic               bs_found,
  input  logic [IDX_W-1:0]   bs_index,
  output logic [IDX_W-1:0]   lk_index,
  output logic               lk_done,
  output logic               lk_found,
  input  logic               name_done,
  input  logic [NAME_W-1:0]  name_in,
  input  logic               level_done,
  input  logic [LEVEL_W-1:0] level_in,
  output logic               res_valid,
  output logic               res_found,
  output logic               res_timeout,
  output logic [NAME_W-1:0]  res_name,
  output logic [LEVEL_W-1:0] res_level,
  input  logic               res_ack,
  output logic               busy
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StSearch, StLookup, StResult} state_e;

  state_e              state_q;
  logic [TimerW-1:0]   timer_q;
  logic                name_seen_q;
  logic                level_seen_q;
  logic                req_ready_q;
  logic                bs_start_q;
  logic [BIN_W-1:0]    bs_bin_q;
  logic [IDX_W-1:0]    lk_index_q;
  logic                lk_done_q;
  logic                lk_found_q;
  logic                res_valid_q;
  logic                res_found_q;
  logic                res_timeout_q;
  logic [NAME_W-1:0]   res_name_q;
  logic [LEVEL_W-1:0]  res_level_q;
  logic                busy_q;

  logic                timeout_hit;
  logic                both_seen;
  logic [TimerW-1:0]   timer_inc;

  always_comb begin
    timeout_hit = (timer_q == TimerW'(TIMEOUT));
    // A done arriving this very cycle counts, so both units finishing together is handled.
    both_seen   = (name_seen_q | name_done) & (level_seen_q | level_done);
    timer_inc   = (timer_q == {TimerW{1'b1}}) ? timer_q : timer_q + 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      name_seen_q   <= 1'b0;
      level_seen_q  <= 1'b0;
      req_ready_q   <= 1'b1;
      bs_start_q    <= 1'b0;
      bs_bin_q      <= '0;
      lk_index_q    <= '0;
      lk_done_q     <= 1'b0;
      lk_found_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      res_found_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      res_name_q    <= '0;
      res_level_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            bs_bin_q    <= req_bin;
            bs_start_q  <= 1'b1;
            timer_q     <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StSearch;
          end
        end
        StSearch: begin
          bs_start_q <= 1'b0;
          timer_q    <= timer_inc;
          if (timeout_hit) begin
            res_timeout_q <= 1'b1;
            res_found_q   <= 1'b0;
            res_name_q    <= '0;
            res_level_q   <= '0;
            res_valid_q   <= 1'b1;
            state_q       <= StResult;
          // bs_start_q is high only in the first SEARCH cycle: a done seen then is stale.
          end else if (bs_done && !bs_start_q) begin
            lk_index_q   <= bs_index;
            lk_found_q   <= bs_found;
            lk_done_q    <= 1'b1;
            name_seen_q  <= 1'b0;
            level_seen_q <= 1'b0;
            state_q      <= StLookup;
          end
        end
        StLookup: begin
          timer_q <= timer_inc;
          if (timeout_hit) begin
            lk_done_q     <= 1'b0;
            res_timeout_q <= 1'b1;
            res_found_q   <= 1'b0;
            res_name_q    <= '0;
            res_level_q   <= '0;
            res_valid_q   <= 1'b1;
            state_q       <= StResult;
          end else begin
            // Only the first pulse of each unit is captured.
            if (name_done && !name_seen_q) begin
              res_name_q  <= name_in;
              name_seen_q <= 1'b1;
            end
            if (level_done && !level_seen_q) begin
              res_level_q  <= level_in;
              level_seen_q <= 1'b1;
            end
            if (both_seen) begin
              lk_done_q   <= 1'b0;
              res_found_q <= lk_found_q;
              res_valid_q <= 1'b1;
              state_q     <= StResult;
            end
          end
        end
        StResult: begin
          if (res_ack) begin
            res_valid_q   <= 1'b0;
            res_found_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            res_name_q    <= '0;
            res_level_q   <= '0;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign bs_start    = bs_start_q;
  assign bs_bin      = bs_bin_q;
  assign lk_index    = lk_index_q;
  assign lk_done     = lk_done_q;
  assign lk_found    = lk_found_q;
  assign res_valid   = res_valid_q;
  assign res_found   = res_found_q;
  assign res_timeout = res_timeout_q;
  assign res_name    = res_name_q;
  assign res_level   = res_level_q;
  assign busy        = busy_q;

endmodule
